pc_nested_irq: RTL

Parametrised program-counter register with nested-interrupt support for the iZero MIPS datapath. It holds the current fetch address and loads the next-address mux output each cycle. On an interrupt acknowledge it pushes the current PC onto a hardware return stack and jumps to a per-source vector; on return-from-interrupt it pops the stack. It replaces the single-level PC/backup-register pair.

---
 rtl/pc_nested_irq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pc_nested_irq.sv
// rtl/pc_nested_irq.sv - program counter with hardware return stack for nested interrupts
//
// Holds the current fetch address. Each rising edge it loads addrin, holds it under
// stall, jumps to a per-source vector on inta (pushing the current PC), or pops the
// saved PC on reti. Priority: reset > inta > reti > stall > normal load.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   stall           hold PC (normal load only)
//   inta, irq_id    interrupt acknowledge pulse and source id
//   reti            return-from-interrupt pulse
//   addrin          next sequential/branch address
//   addrout         current PC
//   epc             top-of-stack return address, 0 when empty
//   level           current nesting depth
//   full, empty     level == DEPTH / level == 0
//   irq_taken       one-cycle pulse after an accepted inta
//   ovf_err         sticky: inta refused because the stack was full
//   unf_err         sticky: reti seen with an empty stack

module pc_nested_irq #(
    parameter int          ADDR_W      = 26,
    parameter int          DEPTH       = 4,
    parameter int          IRQ_ID_W    = 3,
    parameter int unsigned RESET_ADDR  = 0,
    parameter int unsigned VECTOR_BASE = 0,
    parameter int          VEC_SHIFT   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         inta,
    input  logic [IRQ_ID_W-1:0]          irq_id,
    input  logic                         reti,
    input  logic [ADDR_W-1:0]            addrin,
    output logic [ADDR_W-1:0]            addrout,
    output logic [ADDR_W-1:0]            epc,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty,
    output logic                         irq_taken,
    output logic                         ovf_err,
    output logic                         unf_err
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] RESET_A = ADDR_W'(RESET_ADDR);
    localparam logic [ADDR_W-1:0] VBASE_A = ADDR_W'(VECTOR_BASE);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [ADDR_W-1:0] stack_q [DEPTH];
    logic [ADDR_W-1:0] stack_d [DEPTH];
    logic              taken_q, taken_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              is_full, is_empty;
    logic [IDX_W-1:0]  push_idx, top_idx;
    logic [ADDR_W-1:0] vector;

    assign is_full  = (level_q == LVL_W'(DEPTH));
    assign is_empty = (level_q == '0);

    // Indices are only used when the stack is not full (push) / not empty (pop),
    // so the truncation never aliases a live entry.
    assign push_idx = IDX_W'(level_q);
    assign top_idx  = IDX_W'(level_q - LVL_W'(1));

    // Unsigned vector arithmetic; bits above ADDR_W are dropped.
    assign vector = VBASE_A + (ADDR_W'(irq_id) << VEC_SHIFT);

    always_comb begin
        addr_d  = addr_q;
        level_d = level_q;
        stack_d = stack_q;
        taken_d = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        if (reset) begin
            addr_d  = RESET_A;
            level_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (inta) begin
            // A concurrent reti is dropped silently whether or not the push succeeds.
            if (!is_full) begin
                stack_d[push_idx] = addr_q;
                level_d           = level_q + LVL_W'(1);
                addr_d            = vector;
                taken_d           = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (reti && !is_empty) begin
            addr_d  = stack_q[top_idx];
            level_d = level_q - LVL_W'(1);
        end else begin
            // Underflowing reti degrades to an ordinary load/stall cycle.
            if (reti) begin
                unf_d = 1'b1;
            end
            if (!stall) begin
                addr_d = addrin;
            end
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        level_q <= level_d;
        stack_q <= stack_d;
        taken_q <= taken_d;
        ovf_q   <= ovf_d;
        unf_q   <= unf_d;
    end

    assign addrout   = addr_q;
    assign epc       = is_empty ? '0 : stack_q[top_idx];
    assign level     = level_q;
    assign full      = is_full;
    assign empty     = is_empty;
    assign irq_taken = taken_q;
    assign ovf_err   = ovf_q;
    assign unf_err   = unf_q;

endmodule
